// File: rtl/lvds_pkg.sv
// Panel timing defaults and image geometry shared by the address generator, image RAM and LVDS packer.
// Also carries the control bundle that travels alongside RAM read data.
package lvds_pkg;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;

    localparam int DEF_IMG_W    = 100;
    localparam int DEF_IMG_H    = 100;
    localparam int DEF_ADDR_W   = 16;
    localparam int PIX_W        = 6;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic img_valid;
        logic frame_start;
    } vid_ctl_t;

    // Blanking state with both syncs deasserted for the given sync polarity.
    function automatic vid_ctl_t ctl_idle(input logic sync_pol);
        vid_ctl_t c;
        c.hsync       = ~sync_pol;
        c.vsync       = ~sync_pol;
        c.de          = 1'b0;
        c.img_valid   = 1'b0;
        c.frame_start = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/lvds_timing_cnt.sv
// Horizontal/vertical panel counters with raw hsync/vsync/de/frame-start decode.
// Latency: decode is combinational on the current count; no backpressure, free-running after reset.
// Backpressure: none, the panel clock never stalls.
module lvds_timing_cnt #(
    parameter int   H_ACTIVE = 1024,
    parameter int   H_FP     = 24,
    parameter int   H_SYNC   = 136,
    parameter int   H_BP     = 160,
    parameter int   V_ACTIVE = 768,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 6,
    parameter int   V_BP     = 29,
    parameter logic SYNC_POL = 1'b0,
    parameter int   HW       = 11,
    parameter int   VW       = 10
) (
    input  logic          clkq,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          frame_end,
    output logic          hs_raw,
    output logic          vs_raw,
    output logic          de_raw,
    output logic          fs_raw
);

    localparam logic [31:0] H_LAST   = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [31:0] V_LAST   = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [31:0] H_ACT    = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT    = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    // Compares run in 32 bits so bounds equal to the total count cannot alias.
    logic [31:0] h32;
    logic [31:0] v32;
    logic        line_end;

    assign h32       = 32'(h_cnt);
    assign v32       = 32'(v_cnt);
    assign line_end  = (h32 == H_LAST);
    assign frame_end = line_end && (v32 == V_LAST);

    always_ff @(posedge clkq) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign hs_raw = ((h32 >= HS_START) && (h32 < HS_END)) ? SYNC_POL : ~SYNC_POL;
    assign vs_raw = ((v32 >= VS_START) && (v32 < VS_END)) ? SYNC_POL : ~SYNC_POL;
    assign de_raw = (h32 < H_ACT) && (v32 < V_ACT);
    assign fs_raw = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/lvds_img_addr_gen.sv
// Panel timing generator and row-major image RAM address sequencer for the LVDS path.
// Latency: addrX/en one clock after the counter position, sync/de/img_valid/frame_start two clocks (RAM aligned).
// Backpressure: none, free-running pixel clock.
module lvds_img_addr_gen
    import lvds_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   IMG_W    = DEF_IMG_W,
    parameter int   IMG_H    = DEF_IMG_H,
    parameter int   IMG_X0   = 0,
    parameter int   IMG_Y0   = 0,
    parameter int   ADDR_W   = DEF_ADDR_W,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic              clkq,
    input  logic              rst,
    output logic [ADDR_W-1:0] addrX,
    output logic [1:0]        en,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              img_valid,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [31:0] WX_LO = 32'(IMG_X0);
    localparam logic [31:0] WX_HI = 32'(IMG_X0 + IMG_W);
    localparam logic [31:0] WY_LO = 32'(IMG_Y0);
    localparam logic [31:0] WY_HI = 32'(IMG_Y0 + IMG_H);

    if (IMG_X0 + IMG_W > H_ACTIVE) begin : g_err_x
        $error("lvds_img_addr_gen: image exceeds active width");
    end
    if (IMG_Y0 + IMG_H > V_ACTIVE) begin : g_err_y
        $error("lvds_img_addr_gen: image exceeds active height");
    end
    if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_err_a
        $error("lvds_img_addr_gen: image does not fit in ADDR_W address space");
    end

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic              frame_end;
    logic              hs_raw;
    logic              vs_raw;
    logic              de_raw;
    logic              fs_raw;
    logic              win;
    logic [ADDR_W-1:0] pix_cnt;
    vid_ctl_t          ctl_raw;
    vid_ctl_t          ctl_s1;
    vid_ctl_t          ctl_s2;

    lvds_timing_cnt #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clkq      (clkq),
        .rst       (rst),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .frame_end (frame_end),
        .hs_raw    (hs_raw),
        .vs_raw    (vs_raw),
        .de_raw    (de_raw),
        .fs_raw    (fs_raw)
    );

    assign win = (32'(h_cnt) >= WX_LO) && (32'(h_cnt) < WX_HI) &&
                 (32'(v_cnt) >= WY_LO) && (32'(v_cnt) < WY_HI);

    // Row-major order means the read address is simply the count of in-window clocks this frame.
    always_ff @(posedge clkq) begin
        if (rst || frame_end) begin
            pix_cnt <= '0;
        end else if (win) begin
            pix_cnt <= pix_cnt + 1'b1;
        end
    end

    always_ff @(posedge clkq) begin
        if (rst) begin
            addrX <= '0;
            en    <= 2'b00;
        end else begin
            if (win) begin
                addrX <= pix_cnt;
            end
            en <= win ? 2'b01 : 2'b00;
        end
    end

    always_comb begin
        ctl_raw             = ctl_idle(SYNC_POL);
        ctl_raw.hsync       = hs_raw;
        ctl_raw.vsync       = vs_raw;
        ctl_raw.de          = de_raw;
        ctl_raw.img_valid   = win;
        ctl_raw.frame_start = fs_raw;
    end

    // Two stages: one for the address register, one for the RAM's registered read data.
    always_ff @(posedge clkq) begin
        if (rst) begin
            ctl_s1 <= ctl_idle(SYNC_POL);
            ctl_s2 <= ctl_idle(SYNC_POL);
        end else begin
            ctl_s1 <= ctl_raw;
            ctl_s2 <= ctl_s1;
        end
    end

    assign hsync       = ctl_s2.hsync;
    assign vsync       = ctl_s2.vsync;
    assign de          = ctl_s2.de;
    assign img_valid   = ctl_s2.img_valid;
    assign frame_start = ctl_s2.frame_start;

endmodule

// File: tb/tb_lvds_img_addr_gen.sv
// Scoreboard bench for lvds_img_addr_gen on a 12x7 panel with a 3x2 image at (2,1).
// Reference expectations come from absolute frame position; resets are inserted at random points.
module tb_lvds_img_addr_gen;

    localparam int HA = 8, HFP = 1, HS = 2, HBP = 1;
    localparam int VA = 4, VFP = 1, VS = 1, VBP = 1;
    localparam int IW = 3, IH = 2, IX0 = 2, IY0 = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;

    logic        clkq = 1'b0;
    logic        rst  = 1'b1;
    logic [15:0] addrX;
    logic [1:0]  en;
    logic        hsync, vsync, de, img_valid, frame_start;

    int errors = 0;
    int checks = 0;

    lvds_img_addr_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .IMG_W (IW), .IMG_H (IH), .IMG_X0 (IX0), .IMG_Y0 (IY0),
        .ADDR_W (16), .SYNC_POL (1'b0)
    ) dut (
        .clkq        (clkq),
        .rst         (rst),
        .addrX       (addrX),
        .en          (en),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .img_valid   (img_valid),
        .frame_start (frame_start)
    );

    always #5 clkq = ~clkq;

    typedef struct {
        int addr;
        int en;
        bit hs;
        bit vs;
        bit de;
        bit iv;
        bit fs;
    } exp_t;

    exp_t exp_q[$];

    function automatic bit in_win(input int p);
        int h = p % HT;
        int v = p / HT;
        return (h >= IX0) && (h < IX0 + IW) && (v >= IY0) && (v < IY0 + IH);
    endfunction

    function automatic int pix_of(input int p);
        return (p / HT - IY0) * IW + (p % HT - IX0);
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: position of the panel counters after each edge, sync outputs lag one more position.
    int  pos = 0;
    int  prev_pos = 0;
    bit  prev_vld = 1'b0;
    int  last_addr = 0;

    always @(posedge clkq) begin
        exp_t e;
        if (rst) begin
            pos = 0; prev_vld = 1'b0; last_addr = 0;
            e = '{addr: 0, en: 0, hs: 1, vs: 1, de: 0, iv: 0, fs: 0};
        end else begin
            if (in_win(pos)) begin
                last_addr = pix_of(pos);
                e.en = 1;
            end else begin
                e.en = 0;
            end
            e.addr = last_addr;
            if (prev_vld) begin
                e.hs = !((prev_pos % HT) >= HA + HFP && (prev_pos % HT) < HA + HFP + HS);
                e.vs = !((prev_pos / HT) >= VA + VFP && (prev_pos / HT) < VA + VFP + VS);
                e.de = (prev_pos % HT) < HA && (prev_pos / HT) < VA;
                e.iv = in_win(prev_pos);
                e.fs = (prev_pos == 0);
            end else begin
                e.hs = 1; e.vs = 1; e.de = 0; e.iv = 0; e.fs = 0;
            end
            prev_pos = pos;
            prev_vld = 1'b1;
            pos = (pos + 1) % FRAME;
        end
        exp_q.push_back(e);
    end

    // Monitor: compares every presented output cycle, plus frame_start period and per-frame en count.
    int  since_fs = 0;
    bit  fs_seen = 1'b0;
    int  en_cnt = 0;

    always @(negedge clkq) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("addrX",       int'(addrX),       e.addr);
            check("en",          int'(en),          e.en);
            check("hsync",       int'(hsync),       int'(e.hs));
            check("vsync",       int'(vsync),       int'(e.vs));
            check("de",          int'(de),          int'(e.de));
            check("img_valid",   int'(img_valid),   int'(e.iv));
            check("frame_start", int'(frame_start), int'(e.fs));
        end
        if (rst) begin
            fs_seen = 1'b0;
            since_fs = 0;
            en_cnt = 0;
        end else begin
            since_fs++;
            if (en == 2'b01) en_cnt++;
            if (frame_start) begin
                if (fs_seen) begin
                    check("fs_period", since_fs, FRAME);
                    check("en_per_frame", en_cnt, IW * IH);
                end
                fs_seen = 1'b1;
                since_fs = 0;
                en_cnt = 0;
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clkq);
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        run(5);
        rst = 1'b0;
        run(3 * FRAME + 20);

        // Reset while the image is mid-read at address 4.
        waited = 0;
        while (!(addrX == 16'd4 && en == 2'b01) && waited < 2 * FRAME) begin
            run(1);
            waited++;
        end
        checks++;
        if (waited >= 2 * FRAME) begin
            errors++;
            $display("FAIL addr4_wait: got timeout after %0d cycles, expected addrX=4", waited);
        end
        rst = 1'b1;
        run(3);
        rst = 1'b0;
        run(2 * FRAME + 10);

        for (int i = 0; i < 6; i++) begin
            rst = 1'b1;
            run($urandom_range(1, 4));
            rst = 1'b0;
            run($urandom_range(1, 2 * FRAME));
        end
        run(FRAME + 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
